// File: rtl/sfq_or2t_capture.sv
// -----------------------------------------------------------------------------
// sfq_or2t_capture
//
// Receiver that sits directly downstream of an OR2T cell. Both the gate clock
// and the cell output are transition encoded: every edge on either line is one
// SFQ pulse. Each gate-clock period becomes one bit (1 if q pulsed during that
// period). Bits are packed LSB-first into WIDTH-bit words and handed out over a
// valid/ready interface with a single holding register.
//
// Ports
//   clk          sampling clock, faster than the minimum SFQ transition spacing
//   rst          synchronous reset, active-high
//   sfq_clk_t    transition-encoded gate clock (same net as the OR2T clk)
//   sfq_q_t      transition-encoded OR2T output q
//   word_data    assembled word, bit 0 = earliest gate cycle
//   word_valid   word_data holds an unconsumed word
//   word_ready   consumer takes the word when word_valid && word_ready
//   bit_count    bits currently sitting in the shift register
//   overflow     sticky: a completed word was dropped (holding register full)
//   multi_pulse  sticky: two or more q pulses inside one gate-cycle window
// -----------------------------------------------------------------------------
module sfq_or2t_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sfq_clk_t,
    input  logic                   sfq_q_t,
    output logic [WIDTH-1:0]       word_data,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [$clog2(WIDTH):0] bit_count,
    output logic                   overflow,
    output logic                   multi_pulse
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_OPEN
    } state_t;

    // Only a definite 1 counts as high; X/Z collapse to 0.
    logic w_clk_raw;
    logic w_q_raw;
    assign w_clk_raw = (sfq_clk_t === 1'b1);
    assign w_q_raw   = (sfq_q_t === 1'b1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_q_sync;
    logic                   r_clk_hist;
    logic                   r_q_hist;

    state_t                 r_state;
    logic                   r_hit;
    logic [WIDTH-1:0]       r_shift;
    logic [CW-1:0]          r_bit_count;
    logic [WIDTH-1:0]       r_word;
    logic                   r_valid;
    logic                   r_overflow;
    logic                   r_multi;

    logic                   w_clk_evt;
    logic                   w_q_evt;
    logic                   w_emit;
    logic                   w_word_done;
    logic                   w_pop;
    logic [WIDTH-1:0]       w_shift_nxt;

    // A transition shows up as a difference between the oldest synced flop and
    // the history flop; both lines share the same depth, so a q pulse caused by
    // a gate clock is never seen before that gate clock.
    assign w_clk_evt = r_clk_sync[SYNC_STAGES-1] ^ r_clk_hist;
    assign w_q_evt   = r_q_sync[SYNC_STAGES-1] ^ r_q_hist;

    always_comb begin
        w_emit      = (r_state == ST_OPEN) && w_clk_evt;
        w_word_done = w_emit && (r_bit_count == CW'(WIDTH - 1));
        w_pop       = r_valid && word_ready;
        w_shift_nxt = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_bit_count == CW'(i)) begin
                w_shift_nxt[i] = r_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Preload the synchronisers with the live levels so that leaving
            // reset does not fabricate an edge.
            r_clk_sync  <= {SYNC_STAGES{w_clk_raw}};
            r_q_sync    <= {SYNC_STAGES{w_q_raw}};
            r_clk_hist  <= w_clk_raw;
            r_q_hist    <= w_q_raw;
            r_state     <= ST_IDLE;
            r_hit       <= 1'b0;
            r_shift     <= '0;
            r_bit_count <= '0;
            r_word      <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_multi     <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], w_clk_raw};
            r_q_sync   <= {r_q_sync[SYNC_STAGES-2:0], w_q_raw};
            r_clk_hist <= r_clk_sync[SYNC_STAGES-1];
            r_q_hist   <= r_q_sync[SYNC_STAGES-1];

            // Window tracking. A q pulse in the same sample as a gate clock
            // belongs to the window that gate clock opens.
            case (r_state)
                ST_IDLE: begin
                    if (w_clk_evt) begin
                        r_state <= ST_OPEN;
                        r_hit   <= w_q_evt;
                    end
                end
                ST_OPEN: begin
                    if (w_clk_evt) begin
                        r_hit <= w_q_evt;
                    end else if (w_q_evt) begin
                        if (r_hit) begin
                            r_multi <= 1'b1;
                        end
                        r_hit <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Packing.
            if (w_emit) begin
                if (w_word_done) begin
                    r_shift     <= '0;
                    r_bit_count <= '0;
                end else begin
                    r_shift     <= w_shift_nxt;
                    r_bit_count <= r_bit_count + CW'(1);
                end
            end

            // Handoff: a completing word may reuse a slot freed this cycle; a
            // freshly loaded word is never consumed on the cycle it lands.
            if (w_word_done) begin
                if (!r_valid || w_pop) begin
                    r_word  <= w_shift_nxt;
                    r_valid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign word_data   = r_word;
    assign word_valid  = r_valid;
    assign bit_count   = r_bit_count;
    assign overflow    = r_overflow;
    assign multi_pulse = r_multi;

endmodule

// File: tb/tb_sfq_or2t_capture.sv
// -----------------------------------------------------------------------------
// tb_sfq_or2t_capture
//
// Drives transition-encoded gate clock and q lines one clk cycle at a time and
// keeps a reference model that works directly on gate-cycle windows: it counts
// q pulses per window, collects one bit per closed window and groups the bits
// into words. Delivered words are compared in order at each handshake.
// -----------------------------------------------------------------------------
module tb_sfq_or2t_capture;

    localparam int W  = 4;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sfq_clk_t = 1'b0;
    logic          sfq_q_t = 1'b0;
    logic          word_ready = 1'b1;
    logic [W-1:0]  word_data;
    logic          word_valid;
    logic [CW-1:0] bit_count;
    logic          overflow;
    logic          multi_pulse;

    sfq_or2t_capture #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sfq_clk_t   (sfq_clk_t),
        .sfq_q_t     (sfq_q_t),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .bit_count   (bit_count),
        .overflow    (overflow),
        .multi_pulse (multi_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_rx     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit           m_started;
    int           m_qcnt;
    bit           m_bits[$];
    logic [W-1:0] exp_words[$];
    bit           m_ready_mode = 1'b1;
    bit           m_held_valid;
    logic [W-1:0] m_held;
    bit           m_overflow;
    bit           m_multi;

    task automatic model_reset();
        m_started    = 1'b0;
        m_qcnt       = 0;
        m_bits.delete();
        exp_words.delete();
        m_held_valid = 1'b0;
        m_held       = '0;
        m_overflow   = 1'b0;
        m_multi      = 1'b0;
    endtask

    task automatic model_word_out(input logic [W-1:0] w);
        if (m_ready_mode) exp_words.push_back(w);
        else if (!m_held_valid) begin
            m_held       = w;
            m_held_valid = 1'b1;
        end else m_overflow = 1'b1;
    endtask

    task automatic model_step(input bit tc, input bit tq);
        logic [W-1:0] w;
        if (tc) begin
            if (m_started) begin
                m_bits.push_back(m_qcnt > 0);
                if (m_bits.size() == W) begin
                    for (int i = 0; i < W; i++) w[i] = m_bits[i];
                    m_bits.delete();
                    model_word_out(w);
                end
            end
            m_started = 1'b1;
            m_qcnt    = tq ? 1 : 0;
        end else if (tq && m_started) begin
            m_qcnt++;
            if (m_qcnt >= 2) m_multi = 1'b1;
        end
    endtask

    // ---------------- handshake monitor ----------------
    always @(negedge clk) begin
        if (!rst && word_valid && word_ready) begin
            n_rx++;
            chk("word_avail", (exp_words.size() != 0), 1);
            if (exp_words.size() != 0) chk("word", word_data, exp_words.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit tc, input bit tq);
        @(posedge clk);
        #1;
        if (tc) sfq_clk_t = ~sfq_clk_t;
        if (tq) sfq_q_t = ~sfq_q_t;
        model_step(tc, tq);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    // One gate event followed by gap-1 quiet cycles; qmask bit c toggles q on
    // cycle c of the window (bit 0 = same sample as the gate clock).
    task automatic gate(input int gap, input int qmask);
        for (int c = 0; c < gap; c++) drive(c == 0, qmask[c]);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        n_rx = 0;
    endtask

    task automatic chk_reset();
        chk("rst_data", word_data, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_bits", bit_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_multi", multi_pulse, 0);
    endtask

    task automatic chk_end();
        idle(8);
        chk("end_bits", bit_count, m_bits.size());
        chk("end_valid", word_valid, m_ready_mode ? 1'b0 : m_held_valid);
        chk("end_ovf", overflow, m_overflow);
        chk("end_multi", multi_pulse, m_multi);
        chk("end_drain", exp_words.size(), 0);
        if (!m_ready_mode && m_held_valid) chk("end_held", word_data, m_held);
    endtask

    // q three cycles after gate events 1 and 3 of five
    task automatic stim_basic();
        gate(6, 1 << 3);
        gate(6, 0);
        gate(6, 1 << 3);
        gate(6, 0);
        gate(6, 0);
    endtask

    task automatic stim_second();
        idle(3);
        drive(1'b0, 1'b1);     // q after event 5
        idle(2);
        for (int k = 0; k < 4; k++) gate(6, 1 << 3);
    endtask

    initial begin
        // Test 1: basic word
        reset_dut();
        chk_reset();
        stim_basic();
        chk_end();
        chk("t1_word", word_data, 4'b0101);
        chk("t1_nrx", n_rx, 1);

        // Test 2: consumer stalled, second word dropped
        word_ready   = 1'b0;
        m_ready_mode = 1'b0;
        reset_dut();
        stim_basic();
        stim_second();
        chk_end();
        chk("t2_hold", word_data, 4'b0101);
        chk("t2_ovf", overflow, 1);

        // Test 2b: consumer ready, second word 1111
        reset_dut();
        chk_reset();
        word_ready   = 1'b1;
        m_ready_mode = 1'b1;
        stim_basic();
        stim_second();
        chk_end();
        chk("t2b_word", word_data, 4'b1111);
        chk("t2b_nrx", n_rx, 2);

        // Test 3: q in the same sample as gate event 2
        reset_dut();
        gate(6, 0);
        gate(6, 1);
        gate(6, 0);
        gate(6, 0);
        gate(6, 0);
        chk_end();
        chk("t3_word", word_data, 4'b0010);

        // Test 4: two q pulses in one window; flag is sticky
        reset_dut();
        gate(6, (1 << 2) | (1 << 4));
        for (int k = 0; k < 4; k++) gate(6, 0);
        chk_end();
        chk("t4_word", word_data, 4'b0001);
        chk("t4_multi", multi_pulse, 1);
        for (int k = 0; k < 3; k++) gate(4, 1 << 1);
        chk_end();
        chk("t4_sticky", multi_pulse, 1);
        reset_dut();
        chk_reset();

        // Test 5: q before the first gate event is ignored
        reset_dut();
        drive(1'b0, 1'b1);
        idle(2);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        idle(5);
        chk("t5_multi_pre", multi_pulse, 0);
        for (int k = 0; k < 5; k++) gate(6, 0);
        chk_end();
        chk("t5_word", word_data, 4'b0000);
        chk("t5_nrx", n_rx, 1);

        // Test 6: reset after two bits of a word
        reset_dut();
        gate(6, 1 << 2);
        gate(6, 0);
        gate(6, 0);
        idle(8);
        chk("t6_bits_pre", bit_count, 2);
        reset_dut();
        chk_reset();
        for (int k = 0; k < 5; k++) gate(6, 1 << 2);
        chk_end();
        chk("t6_nrx", n_rx, 1);
        chk("t6_word", word_data, 4'b1111);

        // Randomised windows, occasional reset at a quiet point
        reset_dut();
        for (int ev = 0; ev < 300; ev++) begin
            int gap;
            int mask;
            if ($urandom_range(0, 39) == 0) begin
                chk_end();
                reset_dut();
                chk_reset();
            end
            gap  = int'($urandom_range(2, 6));
            mask = 0;
            for (int c = 0; c < gap; c++)
                if ($urandom_range(0, 2) == 0) mask = mask | (1 << c);
            gate(gap, mask);
        end
        chk_end();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
